// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential radix-4 Booth significand multiplier.
package fp_mul_pkg;

  localparam int FRC_W    = 23;
  localparam int MAN_W    = FRC_W + 1;
  localparam int PROD_W   = 2 * MAN_W;
  localparam int ACC_W    = PROD_W + 2;
  localparam int N_DIGITS = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } booth_state_t;

  // Signed radix-4 Booth digit, range -2..+2.
  typedef logic signed [2:0] booth_digit_t;

  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_sel_t;

endpackage

// File: rtl/fp_mul_booth_seq_if.sv
// Operand/product handshake bundle between unpack, the Booth multiplier and normalization.
interface fp_mul_booth_seq_if #(
  parameter int FRC_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic [FRC_W-1:0]       frc_X;
  logic [FRC_W-1:0]       frc_Y;
  logic                   hid_X;
  logic                   hid_Y;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*FRC_W+1:0]     frc_Z_full;
  logic                   norm_n;
  logic                   busy;

  modport master (
    output in_valid, frc_X, frc_Y, hid_X, hid_Y, out_ready,
    input  in_ready, out_valid, frc_Z_full, norm_n, busy
  );

  modport slave (
    input  in_valid, frc_X, frc_Y, hid_X, hid_Y, out_ready,
    output in_ready, out_valid, frc_Z_full, norm_n, busy
  );
endinterface

// File: rtl/fp_mul_booth_seq_enc.sv
// Radix-4 Booth recoder: maps a multiplier bit triple to {neg, two, zero} selects.
module booth_r4_enc
  import fp_mul_pkg::*;
(
  input  logic [2:0] triple,
  output booth_sel_t sel
);

  booth_digit_t digit;

  always_comb begin
    case (triple)
      3'b001, 3'b010: digit = 3'sb001;
      3'b011:         digit = 3'sb010;
      3'b100:         digit = 3'sb110;
      3'b101, 3'b110: digit = 3'sb111;
      default:        digit = 3'sb000;
    endcase
  end

  assign sel.neg  = digit[2];
  assign sel.two  = (digit == 3'sb010) || (digit == 3'sb110);
  assign sel.zero = (digit == 3'sb000);

endmodule

// File: rtl/fp_mul_booth_seq.sv
// Sequential radix-4 Booth significand multiplier: one Booth digit per cycle, 13 digits,
// exact 48-bit unsigned product behind valid/ready handshakes.
module fp_mul_booth_seq #(
  parameter int FRC_W = 23
) (
  input logic               clk,
  input logic               rst_n,
  fp_mul_booth_seq_if.slave bus
);
  import fp_mul_pkg::*;

  localparam int MW     = FRC_W + 1;
  localparam int PW     = 2 * MW;
  localparam int AW     = PW + 2;
  localparam int YW     = MW + 3;
  localparam int DIGITS = (MW + 2) / 2;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] acc;
  logic [AW-1:0] mcand;   // multiplicand already weighted by 4^cnt
  logic [YW-1:0] mplier;  // current Booth triple sits in bits [2:0]
  logic [AW-1:0] pp;
  logic [AW-1:0] acc_sum;
  logic          accept;
  logic          last;
  booth_sel_t    sel;

  assign bus.in_ready = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last         = (cnt == 4'(DIGITS - 1));

  booth_r4_enc u_enc (
    .triple (mplier[2:0]),
    .sel    (sel)
  );

  // Partial products are formed at full accumulator width, so negation is the
  // sign-extended two's complement of the shifted multiple.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    pp = '0;
    if (!sel.zero) begin
      pp = sel.two ? (mcand << 1) : mcand;
      if (sel.neg) pp = -pp;
    end
    acc_sum = acc + pp;
  end

  // NOTE: datapath registers are reset too: the spec requires product and accumulator
  // to read zero after reset, and there is no memory here that would make that costly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      bus.out_valid  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frc_Z_full <= '0;
      bus.norm_n     <= 1'b0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state         <= S_BUSY;
      cnt           <= '0;
      acc           <= '0;
      mcand         <= AW'({bus.hid_X, bus.frc_X});
      mplier        <= {2'b00, bus.hid_Y, bus.frc_Y, 1'b0};
      bus.busy      <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        S_BUSY: begin
          acc    <= acc_sum;
          mcand  <= mcand << 2;
          mplier <= mplier >> 2;
          cnt    <= cnt + 4'd1;
          if (last) begin
            state          <= S_DONE;
            bus.busy       <= 1'b0;
            bus.out_valid  <= 1'b1;
            bus.frc_Z_full <= acc_sum[PW-1:0];
            bus.norm_n     <= acc_sum[PW-1];
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Randomized scoreboard bench for fp_mul_booth_seq: stimulus pushes expected products,
// a monitor pops and compares on each output handshake and checks timing/hold behaviour.
module tb_fp_mul_booth_seq;

  typedef struct {
    logic [47:0] prod;
    int          stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_mul_booth_seq_if #(.FRC_W(23)) bus ();

  fp_mul_booth_seq #(.FRC_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   last_acc = 0;
  bit   rand_bp  = 1'b0;
  exp_t sb[$];

  logic        prev_ov   = 1'b0;
  logic        prev_or   = 1'b0;
  logic        prev_busy = 1'b0;
  logic [47:0] held_z    = '0;
  int          busy_run  = 0;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference: plain unsigned multiplication of the two significands.
  function automatic logic [47:0] golden(input logic hx, input logic [22:0] fx,
                                         input logic hy, input logic [22:0] fy);
    longint unsigned a;
    longint unsigned b;
    a = longint'({hx, fx});
    b = longint'({hy, fy});
    return 48'(a * b);
  endfunction

  task automatic issue(input logic hx, input logic [22:0] fx,
                       input logic hy, input logic [22:0] fy);
    int w;
    exp_t e;
    @(posedge clk); #1;
    bus.hid_X = hx; bus.frc_X = fx;
    bus.hid_Y = hy; bus.frc_Y = fy;
    bus.in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      w++;
      if (w > 500) break;
    end
    if (w > 500) begin
      bound_fail("accept_timeout");
    end else begin
      e.prod  = golden(hx, fx, hy, fy);
      e.stamp = cyc;
      sb.push_back(e);
      last_acc = cyc;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Scramble operands after the accept edge; the product must not depend on them.
    bus.frc_X = 23'($urandom);
    bus.frc_Y = 23'($urandom);
    bus.hid_X = 1'($urandom);
    bus.hid_Y = 1'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      bound_fail("drain_timeout");
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: compares on each output handshake and checks latency, busy width and hold.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov   = 1'b0;
        prev_or   = 1'b0;
        prev_busy = 1'b0;
        busy_run  = 0;
      end else begin
        if (bus.busy) begin
          busy_run++;
        end else if (prev_busy) begin
          check("busy_cycles", 64'(busy_run), 64'd13);
          busy_run = 0;
        end
        if (prev_ov && !prev_or) begin
          check("hold_valid", 64'(bus.out_valid), 64'd1);
          check("hold_product", 64'(bus.frc_Z_full), 64'(held_z));
        end
        if (bus.out_valid && !bus.out_ready)
          check("in_ready_backpressure", 64'(bus.in_ready), 64'd0);
        if (bus.out_valid && !prev_ov) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got out_valid with no pending operation (cycle %0d)", cyc);
          end else begin
            check("latency", 64'(cyc - sb[0].stamp), 64'd14);
          end
        end
        if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("product", 64'(bus.frc_Z_full), 64'(mon_e.prod));
          check("norm_n", 64'(bus.norm_n), 64'(mon_e.prod[47]));
        end
        prev_ov   = bus.out_valid;
        prev_or   = bus.out_ready;
        prev_busy = bus.busy;
        held_z    = bus.frc_Z_full;
      end
    end
  end

  // Random output backpressure, enabled only during the random phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int t0;
    int t_rel;
    int w;
    logic        hx, hy;
    logic [22:0] fx, fy;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.frc_X = '0; bus.frc_Y = '0;
    bus.hid_X = 1'b0; bus.hid_Y = 1'b0;
    bus.out_ready = 1'b1;
    t_rel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_product", 64'(bus.frc_Z_full), 64'd0);
    check("rst_norm_n", 64'(bus.norm_n), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.0 x 1.0 and maximum significands.
    issue(1'b1, 23'h000000, 1'b1, 23'h000000); drain();
    issue(1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF); drain();

    // Back-to-back with out_ready held high.
    issue(1'b1, 23'h400000, 1'b1, 23'h400000);
    t0 = last_acc;
    issue(1'b1, 23'h2DF854, 1'b1, 23'h490FDB);
    check("b2b_spacing", 64'(last_acc - t0), 64'd14);
    drain();

    // Subnormal operands.
    issue(1'b0, 23'h000000, 1'b1, 23'h490FDB); drain();
    issue(1'b0, 23'h2DF854, 1'b1, 23'h490FDB); drain();

    // Backpressure in DONE, with the next operands pending.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(1'b1, 23'h123456, 1'b1, 23'h654321);
    w = 0;
    while (!bus.out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.out_valid) bound_fail("bp_valid_timeout");
    fork
      issue(1'b1, 23'h0F0F0F, 1'b0, 23'h7F00FF);
      begin
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        t_rel = cyc;
      end
    join
    check("bp_accept_on_release", 64'(last_acc - t_rel), 64'd0);
    drain();

    // Asynchronous reset while cnt = 6.
    issue(1'b1, 23'h400000, 1'b1, 23'h400000);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_product", 64'(bus.frc_Z_full), 64'd0);
    check("midrst_norm_n", 64'(bus.norm_n), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 23'h400000, 1'b1, 23'h400000); drain();

    // Random operands with random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      hx = 1'($urandom_range(0, 3) != 0);
      hy = 1'($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       fx = 23'h000000;
        1:       fx = 23'h7FFFFF;
        default: fx = 23'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       fy = 23'h000000;
        1:       fy = 23'h7FFFFF;
        default: fy = 23'($urandom);
      endcase
      issue(hx, fx, hy, fy);
    end
    drain();
    rand_bp = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_mul_booth_seq.md
# fp_mul_booth_seq

Iterative radix-4 Booth mantissa multiplier for the single-precision FP multiplier. It takes the two 24-bit significands (hidden bit plus 23-bit fraction) from the unpack/classify logic. It produces the exact 48-bit product `frc_Z_full` and the `norm_n` flag consumed by the normalization stage. It replaces the combinational array with a 13-cycle sequential datapath behind valid/ready handshakes on both sides.

## Interface
- `FRC_W`, default 23: fraction width; significand is `FRC_W+1`, product is `2*(FRC_W+1)`.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `frc_X`, `frc_Y`  in  23 each  fraction fields.
- `hid_X`, `hid_Y`  in  1 each  hidden bits: 1 for normal operands, 0 for subnormal or zero.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  normalization stage accepts the product.
- `frc_Z_full`  out  48  product `{hid_X,frc_X} * {hid_Y,frc_Y}`, unsigned.
- `norm_n`  out  1  equals `frc_Z_full[47]`.
- `busy`  out  1  high while iterating.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - When `in_valid` is high: latch M = `{hid_X,frc_X}`, latch multiplier Y = `{2'b00,hid_Y,frc_Y,1'b0}` (27 bits, y[-1]=0), clear the 50-bit signed accumulator, set digit counter `cnt`=0, go to BUSY.
- **BUSY:**
  - Each cycle encodes triple `{y[2cnt+1], y[2cnt], y[2cnt-1]}`:
    - 000 or 111 → 0
    - 001 or 010 → +M
    - 011 → +2M
    - 100 → -2M
    - 101 or 110 → -M
  - Adds the partial product, weighted by 4^cnt, to the accumulator; `cnt` increments.
  - When `cnt`=12 the last digit is added and the state goes to DONE. BUSY lasts exactly 13 cycles.
- **DONE:**
  - `out_valid` = 1; `frc_Z_full` = accumulator[47:0]. The accumulator is non-negative and bits 49:48 are 0.
  - Output is held stable while `out_ready`=0.
  - On `out_ready`=1: if `in_valid`=1, load new operands and go to BUSY (back-to-back); otherwise go to IDLE.
- `in_ready` = (state==IDLE) || (state==DONE && `out_ready`). It is low throughout BUSY.
- Latency is constant regardless of operand values. There is no early exit for zero or subnormal operands.
- Operands are sampled only on the accept edge. Input changes during BUSY or DONE are ignored.
- `frc_Z_full` keeps its last value in IDLE; downstream must qualify it with `out_valid`.
- Arithmetic:
  - Accumulator is 50 bits, two's complement.
  - Partial products are sign-extended to 50 bits before shifting.
  - The final result is exact and needs no truncation.
- **Reset:** asserting `rst_n`=0 at any time, including mid-BUSY, forces state IDLE, `cnt`=0, accumulator 0, `frc_Z_full`=0, `out_valid`=0, `busy`=0, `norm_n`=0. `in_ready` is 1 after reset.

## Timing
- **Accept edge T0:** `in_valid` && `in_ready` sampled high.
- **BUSY:** `busy`=1 for cycles T0+1 … T0+13.
- **Output:** `out_valid` rises after edge T0+13 and stays high until the edge where `out_ready` is sampled high.
- **Throughput:** one product per 14 cycles with back-to-back acceptance; more cycles under backpressure.
- All outputs are registered except `in_ready`, which is combinational from state and `out_ready`.

## Structure
- **Shared package `fp_mul_pkg`:**
  - State enum `booth_state_t` with values IDLE, BUSY, DONE.
  - Constants `FRC_W`=23, `MAN_W`=24, `PROD_W`=48, `ACC_W`=50, `N_DIGITS`=13.
  - Digit type: 3-bit signed, range −2…+2.
- **Sub-module `booth_r4_enc`:** combinational; maps a 3-bit triple to `{neg, two, zero}`.
- The top level holds the FSM, counter, operand registers and accumulator.

## Test plan
- 1.0×1.0: hid=1/1, `frc_X`=`frc_Y`=0 → after 13 busy cycles `frc_Z_full`=48'h4000_0000_0000, `norm_n`=0.
- Max significands: `frc_X`=`frc_Y`=23'h7FFFFF, hid=1/1 → `frc_Z_full`=48'hFFFF_FE00_0001, `norm_n`=1.
- 1.5×1.5 (`frc`=23'h400000 each), then `frc_X`=23'h2DF854 × `frc_Y`=23'h490FDB:
  - First result 48'h9000_0000_0000 with `norm_n`=1.
  - Second result matches the golden `{1,frc_X}*{1,frc_Y}`.
  - Issued back-to-back with `out_ready` tied high: 14-cycle spacing between accepts.
- Subnormal and zero: hid_X=0, `frc_X`=0, `frc_Y`=23'h490FDB → `frc_Z_full`=0.
- Subnormal, nonzero: hid_X=0, `frc_X`=23'h2DF854, `frc_Y`=23'h490FDB → result equals the golden `{0,frc_X}*{1,frc_Y}`.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_valid` and `frc_Z_full` held stable, `in_ready`=0. On the release cycle, a pending `in_valid` is accepted.
- Reset at `cnt`=6: drive `rst_n` low asynchronously → `out_valid`, `busy`, `frc_Z_full` go to 0 immediately and `in_ready`=1. Then a new 1.5×1.5 operation completes correctly.
